// File: rtl/uart_csr_pkg.sv
// Shared constants, FSM state type and CRC-8 helper for the UART CSR bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_csr_pkg;

    localparam logic [7:0] SOF_REQ = 8'hA5;
    localparam logic [7:0] SOF_RSP = 8'h5A;

    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;

    localparam logic [7:0] ST_OK   = 8'h00;
    localparam logic [7:0] ST_CRC  = 8'h01;
    localparam logic [7:0] ST_ILL  = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CRC,
        S_EXEC,
        S_RESP
    } bridge_state_e;

    // CRC-8, poly 0x07, MSB-first, no reflection: fold one byte into the running value
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_csr_bridge.sv
// Parses framed host commands from an RX byte stream, issues single-cycle CSR accesses and returns ack/read frames on TX.
// Latency: CRC byte accepted at cycle N, CSR strobe at N+1, first response byte (0x5A) valid at N+2.
// Backpressure: rx_ready low in EXEC/RESP; TX bytes held until tx_ready, sent back-to-back; UART_BRIDGE_TIMEOUT_EN adds an inter-byte timeout.
module uart_csr_bridge
    import uart_csr_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk_gated,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    input  logic              uart_crc_en,
    output logic              csr_wen,
    output logic              csr_ren,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [31:0]       csr_wdata,
    input  logic [31:0]       csr_rdata,
    output logic              rx_crc_error,
    output logic              rx_illegal_cmd,
    output logic              busy
);

    bridge_state_e state;
    logic [7:0]    cmd_q;
    logic [7:0]    addr_q;
    logic [7:0]    crc_q;
    logic [7:0]    status_q;
    logic [31:0]   wdata_q;
    logic [1:0]    dcnt_q;
    logic [7:0]    rsp_buf [7];
    logic [2:0]    rsp_idx;
    logic [2:0]    rsp_last;

    logic          rx_fire;
    logic          tx_fire;
    logic          timeout_hit;
    logic [7:0]    crc_next;
    logic [7:0]    status_next;
    logic [7:0]    rd_crc;
    logic [7:0]    err_crc;

    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    assign rx_ready = (state != S_EXEC) && (state != S_RESP);
    assign busy     = (state != S_IDLE);
    assign crc_next = crc8_step(crc_q, rx_data);

    // Classify the frame as its CRC byte arrives: CRC error outranks a bad command or misaligned address
    always_comb begin
        status_next = ST_OK;
        if (uart_crc_en && (rx_data != crc_q)) begin
            status_next = ST_CRC;
        end else if (((cmd_q != CMD_WR) && (cmd_q != CMD_RD)) || (addr_q[1:0] != 2'b00)) begin
            status_next = ST_ILL;
        end
    end

    // Response CRCs: STATUS plus read data for a good read, STATUS alone otherwise
    always_comb begin
        rd_crc  = crc8_step(8'h00, ST_OK);
        rd_crc  = crc8_step(rd_crc, csr_rdata[7:0]);
        rd_crc  = crc8_step(rd_crc, csr_rdata[15:8]);
        rd_crc  = crc8_step(rd_crc, csr_rdata[23:16]);
        rd_crc  = crc8_step(rd_crc, csr_rdata[31:24]);
        err_crc = crc8_step(8'h00, status_q);
    end

`ifdef UART_BRIDGE_TIMEOUT_EN
    logic [31:0] gap_q;
    logic        in_frame;

    assign in_frame    = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA) || (state == S_CRC);
    assign timeout_hit = in_frame && !rx_fire && (gap_q == 32'(TIMEOUT_CYC - 1));

    // Idle-cycle counter between RX bytes of one frame; cleared on every accepted byte
    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else if (!in_frame || rx_fire || timeout_hit) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_q + 32'd1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
`endif

    // Frame FSM with registered strobes, error pulses and response serializer
    always_ff @(posedge clk_gated or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cmd_q          <= '0;
            addr_q         <= '0;
            crc_q          <= '0;
            status_q       <= '0;
            wdata_q        <= '0;
            dcnt_q         <= '0;
            rsp_idx        <= '0;
            rsp_last       <= '0;
            for (int i = 0; i < 7; i++) begin
                rsp_buf[i] <= '0;
            end
            tx_valid       <= 1'b0;
            tx_data        <= '0;
            csr_wen        <= 1'b0;
            csr_ren        <= 1'b0;
            csr_addr       <= '0;
            csr_wdata      <= '0;
            rx_crc_error   <= 1'b0;
            rx_illegal_cmd <= 1'b0;
        end else begin
            csr_wen        <= 1'b0;
            csr_ren        <= 1'b0;
            rx_crc_error   <= 1'b0;
            rx_illegal_cmd <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rx_fire && (rx_data == SOF_REQ)) begin
                        crc_q <= 8'h00;
                        state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (rx_fire) begin
                        cmd_q <= rx_data;
                        crc_q <= crc_next;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // Anything but a write (including an unknown command) is read-length
                    if (rx_fire) begin
                        addr_q <= rx_data;
                        crc_q  <= crc_next;
                        dcnt_q <= 2'd0;
                        state  <= (cmd_q == CMD_WR) ? S_DATA : S_CRC;
                    end
                end
                S_DATA: begin
                    if (rx_fire) begin
                        wdata_q <= {rx_data, wdata_q[31:8]};
                        crc_q   <= crc_next;
                        dcnt_q  <= dcnt_q + 2'd1;
                        if (dcnt_q == 2'd3) begin
                            state <= S_CRC;
                        end
                    end
                end
                S_CRC: begin
                    if (rx_fire) begin
                        status_q <= status_next;
                        state    <= S_EXEC;
                        if (status_next == ST_OK) begin
                            csr_addr <= ADDR_W'(addr_q);
                            if (cmd_q == CMD_WR) begin
                                csr_wen   <= 1'b1;
                                csr_wdata <= wdata_q;
                            end else begin
                                csr_ren   <= 1'b1;
                            end
                        end else if (status_next == ST_CRC) begin
                            rx_crc_error   <= 1'b1;
                        end else begin
                            rx_illegal_cmd <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    // csr_rdata is only valid during the read strobe, so capture it here
                    rsp_buf[0] <= SOF_RSP;
                    rsp_buf[1] <= status_q;
                    if ((status_q == ST_OK) && (cmd_q == CMD_RD)) begin
                        rsp_buf[2] <= csr_rdata[7:0];
                        rsp_buf[3] <= csr_rdata[15:8];
                        rsp_buf[4] <= csr_rdata[23:16];
                        rsp_buf[5] <= csr_rdata[31:24];
                        rsp_buf[6] <= rd_crc;
                        rsp_last   <= 3'd6;
                    end else begin
                        rsp_buf[2] <= err_crc;
                        rsp_last   <= 3'd2;
                    end
                    rsp_idx  <= 3'd0;
                    tx_valid <= 1'b1;
                    tx_data  <= SOF_RSP;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (tx_fire) begin
                        if (rsp_idx == rsp_last) begin
                            tx_valid <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            rsp_idx <= rsp_idx + 3'd1;
                            tx_data <= rsp_buf[rsp_idx + 3'd1];
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A stalled frame is abandoned silently apart from the illegal pulse
            if (timeout_hit) begin
                state          <= S_IDLE;
                rx_illegal_cmd <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_csr_bridge.sv
// Scoreboard bench for uart_csr_bridge: frames are modelled at byte/frame level, expectations queued at issue time.
// Latency: monitors check strobe at CRC-accept+1 and first TX byte at CRC-accept+2.
// Backpressure: tx_ready driven always-on, random, or held low 5 cycles per byte.
`timescale 1ns/1ps
module tb_uart_csr_bridge;

    logic        clk_gated = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        uart_crc_en;
    logic        csr_wen;
    logic        csr_ren;
    logic [7:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        rx_crc_error;
    logic        rx_illegal_cmd;
    logic        busy;

    always #5 clk_gated = ~clk_gated;

    uart_csr_bridge #(.ADDR_W(8), .TIMEOUT_CYC(16)) dut (
        .clk_gated      (clk_gated),
        .rst_n          (rst_n),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .uart_crc_en    (uart_crc_en),
        .csr_wen        (csr_wen),
        .csr_ren        (csr_ren),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .rx_crc_error   (rx_crc_error),
        .rx_illegal_cmd (rx_illegal_cmd),
        .busy           (busy)
    );

    localparam int K_WEN = 0;
    localparam int K_REN = 1;
    localparam int K_CRC = 2;
    localparam int K_ILL = 3;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] wd;
        bit          chk_cyc;
    } ev_t;

    typedef struct {
        logic [7:0] dat;
        bit         last;
    } txb_t;

    ev_t  ev_q[$];
    txb_t tx_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_crc_hs = -100;
    int bp_mode = 0;
    int stall = 0;
    bit tx_hs_neg = 1'b0;
    bit prev_v = 1'b0;
    bit prev_stall = 1'b0;
    bit mid_frame = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk_gated) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference CRC-8 (poly 0x07) done as bit-serial long division over the message
    function automatic logic [7:0] ref_crc(input logic [7:0] m[$]);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (m[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ m[i][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // tx_ready driver
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk_gated);
            #1;
            if (bp_mode == 0) begin
                tx_ready = 1'b1;
            end else if (bp_mode == 1) begin
                tx_ready = 1'($urandom_range(0, 1));
            end else begin
                if (tx_hs_neg) stall = 0;
                if (tx_valid && stall < 5) begin
                    tx_ready = 1'b0;
                    stall++;
                end else begin
                    tx_ready = 1'b1;
                end
            end
        end
    end

    // TX monitor: byte order, hold under stall, back-to-back, latency, rx_ready low in RESP
    always @(negedge clk_gated) begin
        txb_t e;
        if (tx_valid && !prev_v) chk("tx_latency", cyc, last_crc_hs + 2);
        if (mid_frame) chk("tx_gap", {31'd0, tx_valid}, 32'd1);
        if (prev_stall && tx_valid) chk("tx_hold", {24'd0, tx_data}, {24'd0, prev_data});
        if (tx_valid) chk("rx_ready_in_resp", {31'd0, rx_ready}, 32'd0);
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                chk("tx_unexpected_byte", {24'd0, tx_data}, 32'h100);
                mid_frame = 1'b0;
            end else begin
                e = tx_q.pop_front();
                chk("tx_byte", {24'd0, tx_data}, {24'd0, e.dat});
                mid_frame = !e.last;
            end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_v     = tx_valid;
        tx_hs_neg  = tx_valid && tx_ready;
    end

    task automatic ev_check(input int kind);
        ev_t e;
        if (ev_q.size() == 0) begin
            chk("unexpected_event", kind, 32'hFFFF);
            return;
        end
        e = ev_q.pop_front();
        chk("event_kind", kind, e.kind);
        if (kind == K_WEN || kind == K_REN) chk("csr_addr", {24'd0, csr_addr}, {24'd0, e.addr});
        if (kind == K_WEN) chk("csr_wdata", csr_wdata, e.wd);
        if (e.chk_cyc) chk("event_latency", cyc, last_crc_hs + 1);
    endtask

    // Strobe / pulse monitor
    always @(negedge clk_gated) begin
        if (csr_wen)        ev_check(K_WEN);
        if (csr_ren)        ev_check(K_REN);
        if (rx_crc_error)   ev_check(K_CRC);
        if (rx_illegal_cmd) ev_check(K_ILL);
    end

    task automatic send_byte(input logic [7:0] b, output int hs);
        int gap;
        bit got;
        gap = $urandom_range(0, 2);
        got = 1'b0;
        hs  = -100;
        repeat (gap) begin
            @(posedge clk_gated);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk_gated);
            if (rx_ready) begin
                got = 1'b1;
                hs  = cyc;
            end
        end
        if (!got) chk("rx_accept_timeout", 32'd0, 32'd1);
        @(posedge clk_gated);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((tx_q.size() != 0 || ev_q.size() != 0 || busy) && n < 600) begin
            @(negedge clk_gated);
            n++;
        end
        chk("drain_in_budget", {31'd0, (n < 600)}, 32'd1);
        tx_q.delete();
        ev_q.delete();
        @(posedge clk_gated);
        #1;
    endtask

    // crc_mode: 0 correct CRC byte, 1 one bit flipped, 2 literal 0x00
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input bit crc_en, input int crc_mode, input int junk);
        logic [7:0] msg[$];
        logic [7:0] pay[$];
        logic [7:0] good;
        logic [7:0] sent;
        logic [7:0] st;
        logic [7:0] jb;
        ev_t        e;
        txb_t       t;
        int         hs;

        msg = {cmd, addr};
        if (cmd == 8'h01) for (int i = 0; i < 4; i++) msg.push_back(wd[8*i +: 8]);
        good = ref_crc(msg);
        if (crc_mode == 0)      sent = good;
        else if (crc_mode == 1) sent = good ^ (8'h01 << $urandom_range(0, 7));
        else                    sent = 8'h00;

        if (crc_en && sent != good)                                     st = 8'h01;
        else if ((cmd != 8'h01 && cmd != 8'h02) || addr[1:0] != 2'b00) st = 8'h02;
        else                                                            st = 8'h00;

        e.addr = addr;
        e.wd = wd;
        e.chk_cyc = 1'b1;
        if (st == 8'h01)      e.kind = K_CRC;
        else if (st == 8'h02) e.kind = K_ILL;
        else                  e.kind = (cmd == 8'h01) ? K_WEN : K_REN;
        ev_q.push_back(e);

        pay = {st};
        if (st == 8'h00 && cmd == 8'h02) for (int i = 0; i < 4; i++) pay.push_back(rd[8*i +: 8]);
        t.dat = 8'h5A;
        t.last = 1'b0;
        tx_q.push_back(t);
        foreach (pay[i]) begin
            t.dat = pay[i];
            tx_q.push_back(t);
        end
        t.dat = ref_crc(pay);
        t.last = 1'b1;
        tx_q.push_back(t);

        uart_crc_en = crc_en;
        csr_rdata   = rd;
        for (int i = 0; i < junk; i++) begin
            jb = 8'($urandom);
            if (jb == 8'hA5) jb = 8'h00;
            send_byte(jb, hs);
        end
        send_byte(8'hA5, hs);
        foreach (msg[i]) send_byte(msg[i], hs);
        send_byte(sent, hs);
        last_crc_hs = hs;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int hs;
        logic [7:0] cmd;
        logic [7:0] addr;
        int r;

        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        uart_crc_en = 1'b1;
        csr_rdata = 32'h0;
        repeat (3) @(negedge clk_gated);
        chk("rst_csr_wen", {31'd0, csr_wen}, 32'd0);
        chk("rst_csr_ren", {31'd0, csr_ren}, 32'd0);
        chk("rst_csr_addr", {24'd0, csr_addr}, 32'd0);
        chk("rst_csr_wdata", csr_wdata, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_crc_err", {31'd0, rx_crc_error}, 32'd0);
        chk("rst_illegal", {31'd0, rx_illegal_cmd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk_gated);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk_gated);
        #1;

        // Directed frames
        run_frame(8'h02, 8'h3C, 32'h0, 32'h0000_0101, 1'b1, 0, 0);
        run_frame(8'h01, 8'h04, 32'h1234_5678, 32'h0, 1'b1, 0, 2);
        chk("wdata_held", csr_wdata, 32'h1234_5678);
        run_frame(8'h02, 8'h3C, 32'h0, 32'hDEAD_BEEF, 1'b1, 2, 0);
        run_frame(8'h02, 8'h3C, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 0);
        run_frame(8'h07, 8'h04, 32'h0, 32'h0, 1'b1, 0, 0);
        run_frame(8'h02, 8'h05, 32'h0, 32'h0, 1'b1, 0, 0);
        run_frame(8'h01, 8'hA5, 32'hA5A5_A5A5, 32'h0, 1'b1, 0, 1);
        bp_mode = 2;
        run_frame(8'h02, 8'h10, 32'h0, 32'h8421_1248, 1'b1, 0, 0);
        run_frame(8'h01, 8'h20, 32'h0BAD_CAFE, 32'h0, 1'b1, 1, 0);
        bp_mode = 0;

        // Reset in the middle of a frame: nothing comes out, next frame is clean
        send_byte(8'hA5, hs);
        send_byte(8'h02, hs);
        rst_n = 1'b0;
        @(negedge clk_gated);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rx_ready", {31'd0, rx_ready}, 32'd1);
        @(posedge clk_gated);
        #1;
        rst_n = 1'b1;
        @(posedge clk_gated);
        #1;
        run_frame(8'h02, 8'h08, 32'h0, 32'h1357_9BDF, 1'b1, 0, 0);

`ifdef UART_BRIDGE_TIMEOUT_EN
        begin
            ev_t e;
            int n;
            e.kind = K_ILL;
            e.addr = 8'h00;
            e.wd = 32'h0;
            e.chk_cyc = 1'b0;
            send_byte(8'hA5, hs);
            send_byte(8'h01, hs);
            ev_q.push_back(e);
            n = 0;
            while (busy && n < 40) begin
                @(negedge clk_gated);
                n++;
            end
            chk("timeout_to_idle", {31'd0, busy}, 32'd0);
            drain();
            run_frame(8'h01, 8'h0C, 32'hFEED_0001, 32'h0, 1'b1, 0, 0);
        end
`endif

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            r = $urandom_range(0, 9);
            cmd = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom);
            addr = 8'($urandom);
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            bp_mode = $urandom_range(0, 2);
            run_frame(cmd, addr, $urandom, $urandom, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 2));
        end
        bp_mode = 0;

        chk("tx_queue_empty", tx_q.size(), 32'd0);
        chk("ev_queue_empty", ev_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
